// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic Bernstein evaluator: FSM state
// encoding, maximal-length LFSR tap table and a popcount helper.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } sc_state_e;

  localparam int LFSR_MIN_W = 4;
  localparam int LFSR_MAX_W = 16;

  // Feedback tap mask per register width. Bit i set means stage i feeds the
  // XOR that enters stage 0 on a left shift. Every entry is primitive, so the
  // register walks all 2^RW-1 non-zero states.
  function automatic logic [15:0] lfsr_taps(input int rw);
    logic [15:0] t;
    case (rw)
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // Number of set bits in a 32-bit word (callers zero-extend narrower vectors).
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR used as the random number source for the stochastic
// comparator. Never holds zero: reset and a zero seed both map to all-ones.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [RW-1:0] seed,
  input  logic          en,
  output logic [RW-1:0] q
);

  localparam logic [RW-1:0] TAPS = RW'(lfsr_taps(RW));

  logic [RW-1:0] q_r;
  logic [RW-1:0] nxt_s;
  logic          fb_s;

  // Feedback bit from the tapped stages and the shifted next state
  always_comb begin
    fb_s  = ^(q_r & TAPS);
    nxt_s = {q_r[RW-2:0], fb_s};
  end

  // State register: reload from seed (zero seed becomes all-ones) or step when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {RW{1'b1}};
    end else if (load) begin
      q_r <= (seed == {RW{1'b0}}) ? {RW{1'b1}} : seed;
    end else if (en) begin
      q_r <= nxt_s;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/sc_bernstein_eval.sv
// Stochastic Bernstein polynomial evaluator. Each valid sample selects the
// coefficient indexed by the number of ones across the input bitstreams and
// compares it with an LFSR value to produce one output stochastic bit. A run
// consumes len samples and reports the count of output ones.
module sc_bernstein_eval
  import sc_pkg::*;
#(
  parameter int NIN   = 3,
  parameter int RW    = 8,
  parameter int LEN_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [$clog2(NIN+1)-1:0]   cfg_addr,
  input  logic [RW:0]                cfg_data,
  input  logic                       start,
  input  logic [RW-1:0]              seed,
  input  logic [LEN_W-1:0]           len,
  input  logic                       x_valid,
  input  logic [NIN-1:0]             x_bits,
  output logic                       busy,
  output logic                       z_valid,
  output logic                       z_bit,
  output logic                       done,
  output logic [LEN_W-1:0]           ones
);

  localparam int AW = $clog2(NIN+1);
  localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};

  sc_state_e        state_r;
  sc_state_e        state_n_s;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] ones_r;
  logic [RW:0]      coef_r [0:NIN];

  // Snapshot of a coefficient overwritten in the same cycle as the start, so
  // the first sample of the run still sees the value that was in place.
  logic             pend_r;
  logic [AW-1:0]    pend_idx_r;
  logic [RW:0]      pend_val_r;

  logic             busy_r;
  logic             z_valid_r;
  logic             z_bit_r;
  logic             done_r;

  logic [RW-1:0]    lfsr_q_s;
  logic [AW-1:0]    k_s;
  logic [RW:0]      coef_sel_s;
  logic [RW:0]      pend_cap_s;
  logic             b_s;
  logic             start_ok_s;
  logic             consume_s;
  logic             last_s;
  logic             cfg_ok_s;

  sc_lfsr #(.RW(RW)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok_s),
    .seed  (seed),
    .en    (consume_s),
    .q     (lfsr_q_s)
  );

  // Qualify control strobes against the current state
  always_comb begin
    start_ok_s = (state_r == ST_IDLE) && start;
    consume_s  = (state_r == ST_RUN) && x_valid;
    last_s     = (cnt_r == (len_r - CNT_ONE));
    cfg_ok_s   = (state_r == ST_IDLE) && cfg_we && (32'(cfg_addr) <= 32'(NIN));
  end

  // Coefficient select by popcount and the stochastic comparison
  always_comb begin
    k_s = AW'(popcount(32'(x_bits)));
    if (pend_r && (pend_idx_r == k_s)) begin
      coef_sel_s = pend_val_r;
    end else begin
      coef_sel_s = coef_r[k_s];
    end
    b_s = ({1'b0, lfsr_q_s} < coef_sel_s);
    if (cfg_ok_s) begin
      pend_cap_s = coef_r[cfg_addr];
    end else begin
      pend_cap_s = {(RW+1){1'b0}};
    end
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_n_s = (len == CNT_ZERO) ? ST_DONE : ST_RUN;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (x_valid && last_s) begin
          state_n_s = ST_DONE;
        end else begin
          state_n_s = ST_RUN;
        end
      end
      ST_DONE: state_n_s = ST_IDLE;
      default: state_n_s = ST_IDLE;
    endcase
  end

  // Run control: state, captured length, sample counter and saturating ones count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      len_r   <= CNT_ZERO;
      cnt_r   <= CNT_ZERO;
      ones_r  <= CNT_ZERO;
    end else begin
      state_r <= state_n_s;
      if (start_ok_s) begin
        len_r  <= len;
        cnt_r  <= CNT_ZERO;
        ones_r <= CNT_ZERO;
      end else if (consume_s) begin
        cnt_r <= cnt_r + CNT_ONE;
        if (b_s && (ones_r != CNT_MAX)) begin
          ones_r <= ones_r + CNT_ONE;
        end
      end
    end
  end

  // Coefficient flop array, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NIN; i++) begin
        coef_r[i] <= {(RW+1){1'b0}};
      end
    end else if (cfg_ok_s) begin
      coef_r[cfg_addr] <= cfg_data;
    end
  end

  // Hold the pre-write coefficient for the first sample of a run started together with a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r     <= 1'b0;
      pend_idx_r <= {AW{1'b0}};
      pend_val_r <= {(RW+1){1'b0}};
    end else if (start_ok_s) begin
      pend_r     <= cfg_ok_s;
      pend_idx_r <= cfg_addr;
      pend_val_r <= pend_cap_s;
    end else if (consume_s) begin
      pend_r <= 1'b0;
    end
  end

  // Registered outputs: output bit one cycle after its sample, busy/done from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r    <= 1'b0;
      z_valid_r <= 1'b0;
      z_bit_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r    <= (state_n_s == ST_RUN);
      z_valid_r <= consume_s;
      z_bit_r   <= consume_s & b_s;
      done_r    <= (state_n_s == ST_DONE);
    end
  end

  assign busy    = busy_r;
  assign z_valid = z_valid_r;
  assign z_bit   = z_bit_r;
  assign done    = done_r;
  assign ones    = ones_r;

endmodule

// File: tb/tb_sc_bernstein_eval.sv
// Self-checking bench for sc_bernstein_eval: a sample-level reference model
// predicts every output bit and the final ones count; a compare process checks
// the DUT on each cycle its outputs carry information.
module tb_sc_bernstein_eval;

  localparam int NIN   = 3;
  localparam int RW    = 8;
  localparam int LEN_W = 10;
  localparam int CMAX  = 1023;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [8:0] cfg_data;
  logic       start;
  logic [7:0] seed;
  logic [9:0] len;
  logic       x_valid;
  logic [2:0] x_bits;
  logic       busy;
  logic       z_valid;
  logic       z_bit;
  logic       done;
  logic [9:0] ones;

  always #5 clk = ~clk;

  sc_bernstein_eval #(.NIN(NIN), .RW(RW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .seed(seed), .len(len),
    .x_valid(x_valid), .x_bits(x_bits), .busy(busy), .z_valid(z_valid),
    .z_bit(z_bit), .done(done), .ones(ones)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int         m_coef [0:3];
  logic [7:0] m_lfsr;
  bit         exp_q [$];
  int         exp_total;
  int         run_len;
  // observation counters owned by the compare process
  int         got_ones;
  int         zv_cnt;
  int         busy_cnt;
  int         done_cnt;
  int         zlog_n;
  bit         zlog [0:3];
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Golden 8-bit LFSR step: x^8+x^4+x^3+x^2+1 in left-shift Fibonacci form
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Compare process: check every produced bit and the end-of-run report
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (busy) busy_cnt++;
      if (z_valid) begin
        zv_cnt++;
        if (exp_q.size() == 0) begin
          chk("z_unexpected", 32'(z_valid), 32'd0);
        end else begin
          bit e;
          e = exp_q.pop_front();
          chk("z_bit", 32'(z_bit), 32'(e));
          if (e && got_ones < CMAX) got_ones++;
          chk("ones_running", 32'(ones), 32'(got_ones));
          if (zlog_n < 4) zlog[zlog_n] = z_bit;
          zlog_n++;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_ones", 32'(ones), 32'(exp_total));
        chk("done_zv_align", 32'(z_valid), 32'(run_len != 0));
        chk("done_pending", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic wr(input int a, input int v);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_data = 9'(v);
    m_coef[a] = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic wr_all(input int v);
    for (int i = 0; i < 4; i++) wr(i, v);
  endtask

  // One run: drive n samples, predict each output bit, then check the run summary.
  task automatic run(input logic [7:0] sd, input int n, input bit rnd_x, input logic [2:0] xc,
                     input bit gap, input bit noise, input bit we_start, input int we_addr,
                     input int we_val, input bit we_run, input int abort_at);
    int old [0:3];
    int k, c;
    bit b;
    logic [2:0] x;
    old = m_coef;
    m_lfsr = (sd == 8'h00) ? 8'hFF : sd;
    run_len = n; exp_total = 0; got_ones = 0;
    zv_cnt = 0; busy_cnt = 0; done_cnt = 0; zlog_n = 0;
    start = 1'b1; seed = sd; len = 10'(n);
    if (we_start) begin
      cfg_we = 1'b1; cfg_addr = 2'(we_addr); cfg_data = 9'(we_val);
      m_coef[we_addr] = we_val;
    end
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_zv", 32'(z_valid), 32'd0);
        chk("abort_zbit", 32'(z_bit), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ones", 32'(ones), 32'd0);
        exp_q.delete();
        for (int j = 0; j < 4; j++) m_coef[j] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_ones_idle", 32'(ones), 32'd0);
        return;
      end
      x = rnd_x ? 3'($urandom) : xc;
      x_bits = x; x_valid = 1'b1;
      k = $countones(x);
      c = (i == 0 && we_start && k == we_addr) ? old[k] : m_coef[k];
      b = (int'(m_lfsr) < c);
      exp_q.push_back(b);
      if (b && exp_total < CMAX) exp_total++;
      m_lfsr = lfsr_next(m_lfsr);
      if (noise) begin
        start = 1'($urandom); seed = 8'($urandom); len = 10'($urandom);
      end
      if (we_run && i == n / 2) begin
        cfg_we = 1'b1; cfg_addr = 2'(we_addr); cfg_data = 9'(we_val);
      end
      @(posedge clk); #1;
      x_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
      if (gap && i != n - 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("zv_count", 32'(zv_cnt), 32'(n));
    chk("busy_cycles", 32'(busy_cnt), 32'((n == 0) ? 0 : (gap ? 2 * n - 1 : n)));
    chk("ones_final", 32'(ones), 32'(exp_total));
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 9'd0;
    start = 1'b0; seed = 8'd0; len = 10'd0; x_valid = 1'b0; x_bits = 3'd0;
    for (int i = 0; i < 4; i++) m_coef[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zv", 32'(z_valid), 32'd0);
    chk("rst_zbit", 32'(z_bit), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ones", 32'(ones), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // k=2 selects a zero coefficient: ten zero bits
    wr(0, 0); wr(1, 256); wr(2, 0); wr(3, 256);
    run(8'h5A, 10, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    chk("t039_ones", 32'(ones), 32'd0);

    // constant-one stream over a maximal-length run: no wrap
    run(8'h01, 1023, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    chk("t040_ones", 32'(ones), 32'd1023);
    chk("t040_busy", 32'(busy_cnt), 32'd1023);

    // half-probability coefficients, random inputs, ignored starts mid-run
    wr_all(128);
    run(8'hA5, 1000, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, -1);
    chk("t041_z0", 32'(zlog[0]), 32'd0);
    chk("t041_z1", 32'(zlog[1]), 32'd1);
    chk("t041_z2", 32'(zlog[2]), 32'd0);
    chk("t041_z3", 32'(zlog[3]), 32'd1);

    // sparse x_valid: four samples spread over seven run cycles
    run(8'h3C, 4, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    chk("t042_zv", 32'(zv_cnt), 32'd4);

    // zero-length run
    run(8'h11, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    chk("t043_len0_ones", 32'(ones), 32'd0);

    // write during RUN must be ignored; read it back with a constant k=2 run
    wr(2, 256);
    run(8'h29, 20, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, -1);
    run(8'h44, 8, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    chk("t043_readback", 32'(ones), 32'd8);

    // start with a simultaneous write: old coefficient on the first sample only
    wr_all(0);
    run(8'h9C, 6, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 3, 256, 1'b0, -1);
    chk("t033_ones", 32'(ones), 32'd5);

    // reset at sample 5, then the same seed replays from sample 0
    wr_all(128);
    run(8'h77, 10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 5);
    wr_all(128);
    run(8'h77, 10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    chk("t044_z0", 32'(zlog[0]), 32'd1);

    // randomized runs, first one with a zero seed
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) wr(i, $urandom_range(0, 256));
      run((r == 0) ? 8'h00 : 8'($urandom), $urandom_range(1, 60), 1'b1, 3'b000,
          1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 256), 1'($urandom), -1);
    end

    // ones is held while idle
    repeat (3) @(posedge clk);
    #1;
    chk("ones_held", 32'(ones), 32'(exp_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_bernstein_eval.md
SC_BERNSTEIN_EVAL -- requirements
Module: sc_bernstein_eval

Interface
REQ-001 Parameter NIN, default 3: number of stochastic input bitstreams; selector range 0..NIN.
REQ-002 Parameter RW, default 8: LFSR and coefficient resolution in bits.
REQ-003 Parameter LEN_W, default 10: width of the stream-length and count fields.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low, on ports clk and rst_n.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cfg_we  in  1  coefficient write strobe.
REQ-008 cfg_addr  in  clog2(NIN+1)  coefficient index.
REQ-009 cfg_data  in  RW+1  coefficient probability, value/2^RW.
REQ-010 start  in  1  single-cycle run request.
REQ-011 seed  in  RW  LFSR seed, captured on accepted start.
REQ-012 len  in  LEN_W  number of samples to evaluate, captured on accepted start.
REQ-013 x_valid  in  1  x_bits holds a valid sample this cycle.
REQ-014 x_bits  in  NIN  one stochastic bit per input stream.
REQ-015 busy  out  1  high in RUN.
REQ-016 z_valid  out  1  z_bit valid, one cycle after the consuming sample.
REQ-017 z_bit  out  1  output stochastic bit.
REQ-018 done  out  1  single-cycle pulse when the run completes.
REQ-019 ones  out  LEN_W  count of z_bit ones in the last run, held until the next start.

Function
REQ-020 FSM SHALL have states IDLE, RUN and DONE.
REQ-021 Transitions: IDLE->RUN on start; RUN->DONE on the cycle consuming sample number len; DONE->IDLE unconditionally.
REQ-022 Start in IDLE SHALL load the LFSR from seed (seed 0 replaced by all-ones), capture len, and clear ones and the sample counter.
REQ-023 Start in RUN or DONE SHALL be ignored.
REQ-024 Start with len=0 SHALL go IDLE->DONE directly, with ones=0 and no z_valid.
REQ-025 In RUN, each cycle with x_valid=1 SHALL consume one sample: k=popcount(x_bits); b=(lfsr < coef[k]); the LFSR advances once.
REQ-026 Cycles in RUN with x_valid=0 SHALL not advance the LFSR or the counter and SHALL produce z_valid=0 on the next cycle.
REQ-027 LFSR SHALL be a maximal-length Fibonacci LFSR of RW bits; it never holds 0.
REQ-028 Coefficient value 0 or 1 SHALL give a constant-0 stream; coefficient value 2^RW SHALL give a constant-1 stream.
REQ-029 z_bit SHALL equal b registered, with z_valid=1 exactly one cycle after each consumed sample, including the sample that ends the run.
REQ-030 ones SHALL increment by z_bit on each z_valid; with LEN_W bits the maximum count is 2^LEN_W-1 and SHALL not wrap.
REQ-031 done SHALL pulse in the DONE state, aligned with the last z_valid; ones is final in that cycle.
REQ-032 cfg_we SHALL write coef[cfg_addr] only in IDLE; writes in RUN or DONE SHALL be ignored, and writes with cfg_addr>NIN SHALL be ignored.
REQ-033 Start and cfg_we asserted together in IDLE: the write SHALL complete, and the run SHALL use the old coefficient on its first sample, the new one thereafter.

Reset
REQ-034 rst_n low SHALL force: FSM to IDLE, LFSR to all-ones, all coefficients to 0, ones=0, counter=0, busy=0, z_valid=0, z_bit=0, done=0.
REQ-035 Reset asserted mid-run SHALL abort the run without a done pulse, with all outputs at reset values on the next clock edge.

Structure
REQ-036 Package sc_pkg SHALL hold the FSM state enum, the LFSR tap table indexed by RW (4..16), and a popcount function.
REQ-037 The LFSR SHALL be a sub-module sc_lfsr, with parameter RW and ports clk, rst_n, load, seed, en and q.
REQ-038 Coefficients SHALL be held in a flop array of NIN+1 entries, with no RAM macro.

Verification
REQ-039 Test: coef={0,256,0,256}, x_bits=3'b011 constant, len=10 -> k=2, ten z_bit=0, ones=0, done on the cycle of the last z_valid.
REQ-040 Test: coef[3]=256, x_bits=3'b111, len=1023 -> ones=1023 with no wrap, and busy high for exactly 1023 valid cycles.
REQ-041 Test: coef[k]=128 for all k, random x, seed=8'hA5, len=1000 -> ones matches a golden LFSR model exactly (about 500).
REQ-042 Test: x_valid toggling 1,0,1,0 with len=4 -> 4 z_valid pulses spread over 8 cycles, and the LFSR advances 4 times.
REQ-043 Test: len=0 -> done one cycle after start, ones=0, no z_valid; a cfg_we during RUN leaves the coefficient unchanged (read back by the next run).
REQ-044 Test: rst_n low at sample 5 of 10 -> no done, ones=0; a new start with the same seed reproduces the golden sequence from sample 0.
